// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/decoder blocks: duty width, capture FSM
// states and a constant-foldable ceil(log2) helper.
package pwm_pkg;

  localparam int unsigned DUTY_WIDTH = 8;

  typedef enum logic [1:0] {
    StArm,
    StMeasure,
    StDivide
  } cap_state_e;

  // Bits needed to hold values 0..value-1; use clog2(max + 1) to hold max itself.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value == 0) ? 0 : value - 1;
    while (v != 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pwm_capture_div.sv
// Restoring divider producing an 8-bit quotient, one bit per cycle after start_i.
// Assumes the upper COUNT_WIDTH bits of the numerator are below the denominator.
module pwm_capture_div
  import pwm_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              start_i,
  input  logic [COUNT_WIDTH+DUTY_WIDTH-1:0] num_i,
  input  logic [COUNT_WIDTH-1:0]            den_i,
  output logic [DUTY_WIDTH-1:0]             quot_o,
  output logic                              done_o
);

  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [COUNT_WIDTH-1:0] den_q, den_d;
  logic [DUTY_WIDTH-1:0]  low_q, low_d;
  logic [DUTY_WIDTH-1:0]  quot_q, quot_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [COUNT_WIDTH:0] trial;
  logic [COUNT_WIDTH:0] diff;
  logic                 fits;

  assign trial = {rem_q, low_q[DUTY_WIDTH-1]};
  assign diff  = trial - {1'b0, den_q};
  assign fits  = (trial >= {1'b0, den_q});

  always_comb begin
    rem_d  = rem_q;
    den_d  = den_q;
    low_d  = low_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (clear_i) begin
      rem_d  = '0;
      low_d  = '0;
      quot_d = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (start_i) begin
      rem_d  = num_i[COUNT_WIDTH+DUTY_WIDTH-1:DUTY_WIDTH];
      low_d  = num_i[DUTY_WIDTH-1:0];
      den_d  = den_i;
      quot_d = '0;
      cnt_d  = 4'(DUTY_WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Remainder stays below den, so both branches fit COUNT_WIDTH bits.
      rem_d  = fits ? diff[COUNT_WIDTH-1:0] : trial[COUNT_WIDTH-1:0];
      low_d  = {low_q[DUTY_WIDTH-2:0], 1'b0};
      quot_d = {quot_q[DUTY_WIDTH-2:0], fits};
      cnt_d  = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      den_q  <= '0;
      low_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      low_q  <= low_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quot_o = quot_q;
  assign done_o = done_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input decoder: measures period and high time, reports duty on a 0..255 scale.
// Optional PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample majority filter (+2 cycles latency).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned  CLK_FREQ       = 12_000_000,
  parameter int unsigned  MIN_FREQUENCY  = 250,
  localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ / MIN_FREQUENCY,
  localparam int unsigned COUNT_WIDTH    = clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   enable,
  input  logic                   in,
  output logic [DUTY_WIDTH-1:0]  dutyCycle,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   valid,
  output logic                   idle,
  output logic                   overrun
);

  localparam logic [COUNT_WIDTH-1:0] Timeout = COUNT_WIDTH'(TIMEOUT_CYCLES);

  logic sync1_q, sync2_q, prev_q, level, rise;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
      filt_q <= (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

  assign rise = level & ~prev_q;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
    return (value == Timeout) ? value : value + 1'b1;
  endfunction

  cap_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [COUNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [COUNT_WIDTH-1:0] lat_period_q, lat_period_d;
  logic [COUNT_WIDTH-1:0] out_period_q, out_period_d;
  logic [DUTY_WIDTH-1:0]  duty_q, duty_d;
  logic                   valid_q, valid_d;
  logic                   idle_q, idle_d;
  logic                   overrun_q, overrun_d;

  logic                  div_start, div_clear, div_done;
  logic [DUTY_WIDTH-1:0] div_quot;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = sat_inc(period_cnt_q);
    high_cnt_d   = level ? sat_inc(high_cnt_q) : high_cnt_q;
    lat_period_d = lat_period_q;
    out_period_d = out_period_q;
    duty_d       = duty_q;
    idle_d       = idle_q;
    valid_d      = 1'b0;
    overrun_d    = 1'b0;
    div_start    = 1'b0;
    div_clear    = 1'b0;
    if (!enable) begin
      state_d      = StArm;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      div_clear    = 1'b1;
    end else begin
      unique case (state_q)
        StArm: begin
          if (rise) begin
            period_cnt_d = '0;
            high_cnt_d   = COUNT_WIDTH'(1);
            state_d      = StMeasure;
          end
        end
        StMeasure: begin
          if (period_cnt_q == Timeout) begin
            duty_d       = level ? '1 : '0;
            out_period_d = '0;
            valid_d      = 1'b1;
            idle_d       = 1'b1;
            state_d      = StArm;
          end else if (rise) begin
            // The rising cycle itself is high and belongs to the next interval.
            div_start    = 1'b1;
            lat_period_d = period_cnt_q + 1'b1;
            period_cnt_d = '0;
            high_cnt_d   = COUNT_WIDTH'(1);
            state_d      = StDivide;
          end
        end
        StDivide: begin
          if (rise) begin
            overrun_d    = 1'b1;
            period_cnt_d = '0;
            high_cnt_d   = COUNT_WIDTH'(1);
          end
          if (div_done) begin
            duty_d       = div_quot;
            out_period_d = lat_period_q;
            valid_d      = 1'b1;
            idle_d       = 1'b0;
            state_d      = StMeasure;
          end
        end
        default: state_d = StArm;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= StArm;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      lat_period_q <= '0;
      out_period_q <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      idle_q       <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      lat_period_q <= lat_period_d;
      out_period_q <= out_period_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      idle_q       <= idle_d;
      overrun_q    <= overrun_d;
    end
  end

  pwm_capture_div #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_div (
    .clk_i  (clk),
    .rst_ni (nRst),
    .clear_i(div_clear),
    .start_i(div_start),
    .num_i  ({high_cnt_q, {DUTY_WIDTH{1'b0}}}),
    .den_i  (period_cnt_q + 1'b1),
    .quot_o (div_quot),
    .done_o (div_done)
  );

  assign dutyCycle = duty_q;
  assign period    = out_period_q;
  assign valid     = valid_q;
  assign idle      = idle_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: an event-level model predicts every valid/overrun
// pulse from the sampled input history; a negedge monitor pops and compares.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int unsigned CLK_FREQ = 12_000_000;
  localparam int unsigned MIN_FREQ = 900;
  localparam int unsigned T        = CLK_FREQ / MIN_FREQ;
  localparam int unsigned CW       = clog2(T + 1);
  localparam int          MAXC     = 100_000;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          enable = 1'b0;
  logic          pwm_in = 1'b0;
  logic [7:0]    duty;
  logic [CW-1:0] per;
  logic          valid, idle, overrun;
  bit            en_val = 1'b1;

  pwm_capture #(
    .CLK_FREQ     (CLK_FREQ),
    .MIN_FREQUENCY(MIN_FREQ)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .enable   (enable),
    .in       (pwm_in),
    .dutyCycle(duty),
    .period   (per),
    .valid    (valid),
    .idle     (idle),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int duty;
    int per;
    bit idle;
  } exp_t;

  exp_t exp_q[$];
  int   ovr_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   hist [0:MAXC-1];
  int   cum  [0:MAXC-1];

  // Model state: waiting for first edge, measuring, or busy until pend.t.
  bit   armed = 1'b1;
  bit   busy = 1'b0;
  int   last_rise = 0;
  exp_t pend;
  int   m_n, m_p, m_h;
  bit   m_rise, m_pub;

  always begin
    @(posedge clk);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget got=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    m_n = cyc;
    hist[m_n] = nRst ? pwm_in : 1'b0;
    cum[m_n]  = ((m_n == 0) ? 0 : cum[m_n-1]) + int'(hist[m_n]);
    // Pin seen at edge k is the edge-detector's "high" at edge k+2.
    m_rise = (m_n >= 3) && hist[m_n-2] && !hist[m_n-3];
    if (!nRst || !enable) begin
      armed = 1'b1;
      busy  = 1'b0;
    end else begin
      m_pub = busy && (m_n == pend.t);
      if (armed) begin
        if (m_rise) begin
          armed     = 1'b0;
          last_rise = m_n;
        end
      end else if (busy) begin
        if (m_rise) begin
          ovr_q.push_back(m_n);
          last_rise = m_n;
        end
      end else if (m_n == last_rise + int'(T) + 1) begin
        exp_q.push_back('{m_n, hist[m_n-2] ? 255 : 0, 0, 1'b1});
        armed = 1'b1;
      end else if (m_rise) begin
        m_p  = m_n - last_rise;
        m_h  = cum[m_n-3] - cum[last_rise-3];
        pend = '{m_n + 9, (m_h * 256) / m_p, m_p, 1'b0};
        busy = 1'b1;
        last_rise = m_n;
      end
      if (m_pub) begin
        exp_q.push_back(pend);
        busy = 1'b0;
      end
    end
    cyc = cyc + 1;
  end

  int   mon_now;
  exp_t mon_e;
  int   mon_o;

  always begin
    @(negedge clk);
    mon_now = cyc - 1;
    if (valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid t=%0d got duty=%0d period=%0d idle=%0d required no valid",
                 mon_now, duty, per, idle);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.t != mon_now || int'(duty) != mon_e.duty || int'(per) != mon_e.per ||
            idle != mon_e.idle) begin
          n_bad++;
          $display("FAIL valid_output got t=%0d duty=%0d period=%0d idle=%0d required t=%0d duty=%0d period=%0d idle=%0d",
                   mon_now, duty, per, idle, mon_e.t, mon_e.duty, mon_e.per, mon_e.idle);
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0].t < mon_now) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_valid got none required t=%0d duty=%0d period=%0d",
               mon_e.t, mon_e.duty, mon_e.per);
    end
    if (overrun) begin
      n_cmp++;
      if (ovr_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_overrun got t=%0d required none", mon_now);
      end else begin
        mon_o = ovr_q.pop_front();
        if (mon_o != mon_now) begin
          n_bad++;
          $display("FAIL overrun_time got t=%0d required t=%0d", mon_now, mon_o);
        end
      end
    end
    while (ovr_q.size() > 0 && ovr_q[0] < mon_now) begin
      mon_o = ovr_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_overrun got none required t=%0d", mon_o);
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic step(input bit v);
    @(negedge clk);
    pwm_in = v;
    enable = en_val;
  endtask

  task automatic drive_pwm(input int p, input int h, input int cnt);
    for (int c = 0; c < cnt; c++) begin
      for (int i = 0; i < p; i++) step(i < h);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_duty"}, int'(duty), 0);
    check({tag, "_period"}, int'(per), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_idle"}, int'(idle), 1);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    #1 nRst = 1'b1;
    repeat (5) step(1'b0);

    // 25 % loopback at period 12000: second rise publishes 64.
    drive_pwm(12000, 3000, 2);
    check("loop_duty", int'(duty), 64);
    check("loop_period", int'(per), 12000);
    check("loop_idle", int'(idle), 0);

    repeat (T + 100) step(1'b0);
    check("flat_low_duty", int'(duty), 0);
    check("flat_low_idle", int'(idle), 1);
    repeat (T + 100) step(1'b1);
    check("flat_high_duty", int'(duty), 255);
    check("flat_high_period", int'(per), 0);

    drive_pwm(100, 99, 3);
    check("high99_duty", int'(duty), 253);
    drive_pwm(100, 1, 3);
    check("high1_duty", int'(duty), 2);

    drive_pwm(6, 3, 12);
    drive_pwm(100, 40, 3);
    check("after_short_duty", int'(duty), 102);
    check("after_short_period", int'(per), 100);

    // Drop enable mid-division: outputs held, division discarded.
    drive_pwm(100, 50, 3);
    repeat (5) step(1'b1);
    en_val = 1'b0;
    repeat (45) step(1'b1);
    repeat (50) step(1'b0);
    check("enable_hold_duty", int'(duty), 128);
    en_val = 1'b1;
    drive_pwm(100, 50, 3);

    // Reset while the divider is running.
    drive_pwm(100, 30, 3);
    check("pre_reset_duty", int'(duty), 76);
    repeat (6) step(1'b1);
    #1 nRst = 1'b0;
    #1 check_reset_values("mid_div_reset");
    repeat (2) step(1'b1);
    #1 nRst = 1'b1;
    drive_pwm(100, 30, 3);

    for (int s = 0; s < 20; s++) begin
      int p, h, c;
      p = int'($urandom_range(6, 160));
      h = int'($urandom_range(1, p - 1));
      c = int'($urandom_range(2, 4));
      drive_pwm(p, h, c);
    end

    repeat (30) step(1'b0);
    check("pending_valids", exp_q.size(), 0);
    check("pending_overruns", ovr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
